// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector:
// the found/not-found flag values, clog2, and the next-state table builder.
package seq_det_pkg;

  localparam logic FOUND    = 1'b1;
  localparam logic NOTFOUND = 1'b0;

  localparam int MAX_N   = 16;
  localparam int ENT_W   = 4;
  localparam int TBL_W   = MAX_N * 2 * ENT_W;

  // Width needed to hold 0..v-1, never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

  // Entry (s*2 + b) holds the prefix length reached from state s after bit b.
  function automatic logic [TBL_W-1:0] build_table(input logic [MAX_N-1:0] pat,
                                                    input int n,
                                                    input int overlap);
    logic [TBL_W-1:0] tbl;
    logic [MAX_N-1:0] seq;
    logic             ok;
    logic             bv;
    int               fb;
    int               nxt;
    tbl = '0;
    // Longest proper prefix that is also a suffix of the whole pattern.
    fb = 0;
    for (int k = n - 1; k >= 1; k--) begin
      if (fb == 0) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (pat[n-1-j] != pat[k-1-j]) ok = 1'b0;
        if (ok) fb = k;
      end
    end
    for (int s = 0; s < n; s++) begin
      for (int b = 0; b < 2; b++) begin
        bv = (b != 0);
        if (bv == pat[n-1-s]) begin
          if (s < n - 1) nxt = s + 1;
          else           nxt = (overlap != 0) ? fb : 0;
        end else begin
          seq = '0;
          for (int i = 0; i < s; i++) seq[i] = pat[n-1-i];
          seq[s] = bv;
          nxt = 0;
          for (int k = s; k >= 1; k--) begin
            if (nxt == 0) begin
              ok = 1'b1;
              for (int j = 0; j < k; j++)
                if (pat[n-1-j] != seq[s+1-k+j]) ok = 1'b0;
              if (ok) nxt = k;
            end
          end
        end
        tbl[(s*2+b)*ENT_W +: ENT_W] = ENT_W'(nxt);
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/seq_hit_counter.sv
// Saturating up-counter: advances on inc and sticks at all-ones.
module seq_hit_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count_reg <= '0;
    else if (inc && (count_reg != {W{1'b1}}))
      count_reg <= count_reg + 1'b1;
  end

  assign count = count_reg;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector (Mealy y, registered y_q, optional hit counter).
// Define SEQDET_HITCNT_EN to build the saturating hit counter; otherwise hit_cnt is 0.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1010,
  parameter int           OVERLAP = 0,
  parameter int           CNT_W   = 8,
  localparam int          SW      = clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  output logic             y,
  output logic             y_q,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [SW-1:0]    state_o
);

  localparam logic [MAX_N-1:0] PAT_EXT = MAX_N'(PATTERN);
  localparam logic [TBL_W-1:0] TBL     = build_table(PAT_EXT, N, OVERLAP);

  logic [SW-1:0] state_reg;
  logic [SW-1:0] state_next;
  logic          y_q_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= '0;
      y_q_reg   <= NOTFOUND;
    end else begin
      state_reg <= state_next;
      y_q_reg   <= y;
    end
  end

  always_comb begin
    state_next = state_reg;
    y          = NOTFOUND;
    // An out-of-range state can only come from an upset; recover to empty.
    if (int'(state_reg) >= N) begin
      state_next = '0;
    end else if (en) begin
      state_next = SW'(TBL[(int'(state_reg)*2 + int'(x))*ENT_W +: ENT_W]);
      if ((int'(state_reg) == N - 1) && (x == PATTERN[0]))
        y = FOUND;
    end
  end

  assign y_q     = y_q_reg;
  assign state_o = state_reg;

`ifdef SEQDET_HITCNT_EN
  seq_hit_counter #(
    .W(CNT_W)
  ) u_hit_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (y),
    .count(hit_cnt)
  );
`else
  assign hit_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: defaults, overlap, fallback, en gating,
// mid-pattern reset and counter saturation on a 3-bit all-ones pattern.
module tb_seq_detector_param;

`ifdef SEQDET_HITCNT_EN
  localparam bit HC = 1'b1;
`else
  localparam bit HC = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       en;
  logic       x;

  logic       y0, yq0;
  logic [7:0] cnt0;
  logic [1:0] st0;
  logic       y1, yq1;
  logic [7:0] cnt1;
  logic [1:0] st1;
  logic       y2, yq2;
  logic [1:0] cnt2;
  logic [1:0] st2;

  int checks = 0;
  int errors = 0;

  seq_detector_param dut0 (
    .clk(clk), .reset(reset), .en(en), .x(x),
    .y(y0), .y_q(yq0), .hit_cnt(cnt0), .state_o(st0)
  );

  seq_detector_param #(.OVERLAP(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .x(x),
    .y(y1), .y_q(yq1), .hit_cnt(cnt1), .state_o(st1)
  );

  seq_detector_param #(.N(3), .PATTERN(3'b111), .CNT_W(2), .OVERLAP(1)) dut2 (
    .clk(clk), .reset(reset), .en(en), .x(x),
    .y(y2), .y_q(yq2), .hit_cnt(cnt2), .state_o(st2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a bit at the falling edge; Mealy y is then stable for checking.
  task automatic drive(input logic xv, input logic ev);
    @(negedge clk);
    x  = xv;
    en = ev;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    en = 1'b0;
    x  = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    en = 1'b0;
    x = 1'b0;
    #12;
    checks++;
    if (st0 !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", st0); end
    checks++;
    if (yq0 !== 1'b0) begin errors++; $display("FAIL reset_yq: got %b want 0", yq0); end
    checks++;
    if (cnt0 !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt0); end
    checks++;
    if (y0 !== 1'b0) begin errors++; $display("FAIL reset_y: got %b want 0", y0); end
    @(negedge clk);
    reset = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_basic;
    logic [5:0] xs = 6'b101010;
    int         es[6] = '{1, 2, 3, 0, 1, 2};
    logic [5:0] ey = 6'b000100;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(xs[5-i], 1'b1);
      checks++;
      if (y0 !== ey[5-i]) begin errors++; $display("FAIL basic_y[%0d]: got %b want %b", i+1, y0, ey[5-i]); end
      tick();
      checks++;
      if (int'(st0) != es[i]) begin errors++; $display("FAIL basic_state[%0d]: got %0d want %0d", i+1, st0, es[i]); end
      checks++;
      if (yq0 !== ey[5-i]) begin errors++; $display("FAIL basic_yq[%0d]: got %b want %b", i+1, yq0, ey[5-i]); end
      $display("basic bit %0d x=%b y=%b state=%0d y_q=%b", i+1, xs[5-i], ey[5-i], st0, yq0);
    end
    checks++;
    if (cnt0 !== (HC ? 8'd1 : 8'd0)) begin errors++; $display("FAIL basic_cnt: got %0d want %0d", cnt0, HC ? 1 : 0); end
  endtask

  task automatic test_overlap;
    logic [5:0] xs = 6'b101010;
    int         es[6] = '{1, 2, 3, 2, 3, 2};
    logic [5:0] ey = 6'b000101;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(xs[5-i], 1'b1);
      checks++;
      if (y1 !== ey[5-i]) begin errors++; $display("FAIL overlap_y[%0d]: got %b want %b", i+1, y1, ey[5-i]); end
      tick();
      checks++;
      if (int'(st1) != es[i]) begin errors++; $display("FAIL overlap_state[%0d]: got %0d want %0d", i+1, st1, es[i]); end
      checks++;
      if (yq1 !== ey[5-i]) begin errors++; $display("FAIL overlap_yq[%0d]: got %b want %b", i+1, yq1, ey[5-i]); end
      $display("overlap bit %0d x=%b state=%0d y_q=%b", i+1, xs[5-i], st1, yq1);
    end
    checks++;
    if (cnt1 !== (HC ? 8'd2 : 8'd0)) begin errors++; $display("FAIL overlap_cnt: got %0d want %0d", cnt1, HC ? 2 : 0); end
  endtask

  task automatic test_mismatch;
    logic [7:0] xs = 8'b11011010;
    int         es[8] = '{1, 1, 2, 3, 1, 2, 3, 0};
    logic [7:0] ey = 8'b00000001;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(xs[7-i], 1'b1);
      checks++;
      if (y0 !== ey[7-i]) begin errors++; $display("FAIL mismatch_y[%0d]: got %b want %b", i+1, y0, ey[7-i]); end
      tick();
      checks++;
      if (int'(st0) != es[i]) begin errors++; $display("FAIL mismatch_state[%0d]: got %0d want %0d", i+1, st0, es[i]); end
      $display("mismatch bit %0d x=%b state=%0d", i+1, xs[7-i], st0);
    end
    checks++;
    if (cnt0 !== (HC ? 8'd1 : 8'd0)) begin errors++; $display("FAIL mismatch_cnt: got %0d want %0d", cnt0, HC ? 1 : 0); end
  endtask

  task automatic test_en_gating;
    logic [2:0] xs = 3'b101;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(xs[2-i], 1'b1);
      tick();
    end
    checks++;
    if (st0 !== 2'd3) begin errors++; $display("FAIL gate_pre_state: got %0d want 3", st0); end
    drive(1'b1, 1'b0);
    checks++;
    if (y0 !== 1'b0) begin errors++; $display("FAIL gate_idle_y: got %b want 0", y0); end
    tick();
    checks++;
    if (st0 !== 2'd3) begin errors++; $display("FAIL gate_idle_state: got %0d want 3", st0); end
    checks++;
    if (yq0 !== 1'b0) begin errors++; $display("FAIL gate_idle_yq: got %b want 0", yq0); end
    $display("gate en=0 x=1 state=%0d y_q=%b", st0, yq0);
    drive(1'b0, 1'b1);
    checks++;
    if (y0 !== 1'b1) begin errors++; $display("FAIL gate_hit_y: got %b want 1", y0); end
    tick();
    checks++;
    if (st0 !== 2'd0) begin errors++; $display("FAIL gate_hit_state: got %0d want 0", st0); end
    checks++;
    if (yq0 !== 1'b1) begin errors++; $display("FAIL gate_hit_yq: got %b want 1", yq0); end
    checks++;
    if (cnt0 !== (HC ? 8'd1 : 8'd0)) begin errors++; $display("FAIL gate_cnt: got %0d want %0d", cnt0, HC ? 1 : 0); end
    $display("gate en=1 x=0 state=%0d y_q=%b hit_cnt=%0d", st0, yq0, cnt0);
  endtask

  task automatic test_reset_mid;
    logic [2:0] xs = 3'b101;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(xs[2-i], 1'b1);
      tick();
    end
    checks++;
    if (st0 !== 2'd3) begin errors++; $display("FAIL rstmid_pre_state: got %0d want 3", st0); end
    reset = 1'b0;
    #1;
    checks++;
    if (st0 !== 2'd0) begin errors++; $display("FAIL rstmid_async_state: got %0d want 0", st0); end
    #2;
    reset = 1'b1;
    drive(1'b0, 1'b1);
    checks++;
    if (y0 !== 1'b0) begin errors++; $display("FAIL rstmid_y: got %b want 0", y0); end
    tick();
    checks++;
    if (st0 !== 2'd0) begin errors++; $display("FAIL rstmid_state: got %0d want 0", st0); end
    checks++;
    if (yq0 !== 1'b0) begin errors++; $display("FAIL rstmid_yq: got %b want 0", yq0); end
    checks++;
    if (cnt0 !== 8'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d want 0", cnt0); end
    $display("reset mid-pattern then x=0 state=%0d y_q=%b", st0, yq0);
  endtask

  task automatic test_saturate;
    int         es[8] = '{1, 2, 2, 2, 2, 2, 2, 2};
    logic [7:0] ey = 8'b00111111;
    int         hits = 0;
    logic [1:0] ecnt;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1);
      checks++;
      if (y2 !== ey[7-i]) begin errors++; $display("FAIL sat_y[%0d]: got %b want %b", i+1, y2, ey[7-i]); end
      if (ey[7-i]) hits++;
      tick();
      ecnt = HC ? ((hits > 3) ? 2'd3 : 2'(hits)) : 2'd0;
      checks++;
      if (int'(st2) != es[i]) begin errors++; $display("FAIL sat_state[%0d]: got %0d want %0d", i+1, st2, es[i]); end
      checks++;
      if (cnt2 !== ecnt) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i+1, cnt2, ecnt); end
      checks++;
      if (yq2 !== ey[7-i]) begin errors++; $display("FAIL sat_yq[%0d]: got %b want %b", i+1, yq2, ey[7-i]); end
      $display("saturate bit %0d state=%0d hit_cnt=%0d", i+1, st2, cnt2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_mismatch();
    test_en_gating();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial pattern detector: next generation of the fixed 4-bit Mealy sequence FSMs in this guide series.
- Matches an arbitrary N-bit pattern on a 1-bit serial input, selectable overlap mode, Mealy and registered outputs, saturating hit counter.
- Sits between a serial bit source and downstream control logic that reacts to the detected pattern.

Parameters:
- N, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1010, pattern bits; PATTERN[N-1] is the first bit received, PATTERN[0] the last.
- OVERLAP, 0, 0 = after a match restart from empty; 1 = after a match continue from longest proper suffix (KMP fallback).
- CNT_W, 8, hit counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  bit-valid qualifier; x is consumed only on cycles with en=1.
- x  input  1  serial data bit.
- y  output  1  Mealy found flag, combinational: 1 while the current consumed x completes the pattern.
- y_q  output  1  y registered on the rising edge (one cycle later).
- hit_cnt  output  CNT_W  number of matches since reset, saturating.
- state_o  output  clog2(N)  current matched-prefix length, debug.

Behaviour:
- Reset (reset=0, async): state=0, y_q=0, hit_cnt=0; y=0 because y is gated by state/en.
- State S = number of pattern bits currently matched, 0..N-1. Encoding: binary, width clog2(N). Constants FOUND=1, NOTFOUND=0.
- Expected bit at state S: PATTERN[N-1-S].
- Transitions, evaluated on the rising edge only when en=1:
  - x equals the expected bit and S<N-1: S <= S+1.
  - x equals the expected bit and S=N-1 (match): y=1 in that cycle.
    - OVERLAP=0: S <= 0.
    - OVERLAP=1: S <= F(N), the longest proper prefix of PATTERN that is also a suffix of it.
  - Mismatch: S <= longest k<=S such that the first k pattern bits equal the last k bits of (matched prefix followed by x); can be 0.
- Fallback table (per-state next state for x=0 and x=1) is computed at elaboration by a constant function; no runtime search.
- en=0: S holds, y=0, y_q <= 0, hit_cnt holds.
- y = en & (S==N-1) & (x==PATTERN[0]); purely combinational from S, x, en.
- y_q <= y every rising edge.
- hit_cnt <= hit_cnt+1 on each cycle with y=1; holds at 2^CNT_W-1 (no wrap).
- Illegal S (>=N, only possible via upset): next S=0, y=0.
- Reset asserted mid-pattern: S and partial progress discarded immediately; first bit after release starts from S=0.
- Reset deassertion is not synchronised inside the block; the source is glitch-free and synchronous to clk.

Optional Feature:
- Macro SEQDET_HITCNT_EN.
- Defined: hit_cnt counter instantiated as described.
- Undefined: counter logic omitted; hit_cnt tied to 0; y, y_q and state behaviour unchanged.

Decomposition:
- Package seq_det_pkg holds:
  - FOUND/NOTFOUND constants.
  - clog2 constant function.
  - next-state table builder function (pattern, N, overlap -> per-state next for x=0/1).
- One sub-module, seq_hit_counter: saturating counter with increment and width parameter; instantiated only under SEQDET_HITCNT_EN.

Test Plan:
- Defaults (1010, OVERLAP=0), en=1, x stream 1,0,1,0,1,0 -> y=1 only on bit 4; y_q=1 one cycle later; hit_cnt=1; S sequence 1,2,3,0,1,2.
- Same stream with OVERLAP=1 -> y=1 on bits 4 and 6; hit_cnt=2; S after each match = 2.
- Mismatch fallback, 1010 OVERLAP=0, stream 1,1,0,1,1,0,1,0 -> S: 1,1,2,3,1,2,3,0; single hit on bit 8.
- en gating: stream 1,0,1 with en=1, one cycle en=0 with x=1, then x=0 with en=1 -> hit detected on the en=1 zero; no hit and S=3 held during the en=0 cycle.
- Reset mid-pattern: after 1,0,1 (S=3), pull reset low for 3 ns between edges, then send 0 -> S=0, y=0, hit_cnt=0; no match.
- N=3, PATTERN=3'b111, CNT_W=2, OVERLAP=1, eight consecutive 1s -> hits on bits 3..8; hit_cnt saturates at 3. With SEQDET_HITCNT_EN undefined, hit_cnt stays 0.
